// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter
//   Shares one single-port synchronous RAM between NUM_REQ requesters.
//   Each cycle a round-robin arbiter picks at most one valid request and
//   issues it to the RAM. A tag pipeline matched to the RAM read latency
//   steers each read result back to the requester that issued it.
//
// Ports
//   clk, rst      : clock, synchronous active-high reset
//   req_valid     : per-requester request valid
//   req_ready     : per-requester grant (accept = valid & ready)
//   req_write     : per-requester 1 = write, 0 = read
//   req_addr      : flattened addresses, requester i at [i*ADDR_W +: ADDR_W]
//   req_wdata     : flattened write data, requester i at [i*DATA_W +: DATA_W]
//   rsp_valid     : one-cycle pulse, read data valid for requester i
//   rsp_data      : shared read data, qualified by rsp_valid
//   mem_addr      : RAM address
//   mem_write_en  : RAM write enable
//   mem_data_in   : RAM write data
//   mem_data_out  : RAM read data
module ram_port_arbiter #(
  parameter int NUM_REQ      = 2,
  parameter int ADDR_W       = 8,
  parameter int DATA_W       = 8,
  parameter int READ_LATENCY = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ-1:0]        req_write,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_data,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic                      mem_write_en,
  output logic [DATA_W-1:0]         mem_data_in,
  input  logic [DATA_W-1:0]         mem_data_out
);

  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef struct packed {
    logic            vld;
    logic [ID_W-1:0] id;
  } tag_t;

  localparam int TAG_W = $bits(tag_t);

  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  tag_t [READ_LATENCY-1:0] tag_q, tag_d;

  logic            grant_any;
  logic [ID_W-1:0] grant_id;

  // Round-robin search starting at rr_ptr_q; the sum is one bit wider so the
  // wrap can be done with a single conditional subtract.
  always_comb begin
    logic [ID_W:0]   sum;
    logic [ID_W-1:0] cand;
    grant_any = 1'b0;
    grant_id  = '0;
    sum       = '0;
    cand      = '0;
    for (int unsigned off = 0; off < NUM_REQ; off++) begin
      sum = {1'b0, rr_ptr_q} + (ID_W+1)'(off);
      if (sum >= (ID_W+1)'(NUM_REQ)) sum = sum - (ID_W+1)'(NUM_REQ);
      cand = sum[ID_W-1:0];
      if (!grant_any && req_valid[cand]) begin
        grant_any = 1'b1;
        grant_id  = cand;
      end
    end
    if (rst) grant_any = 1'b0;
  end

  always_comb begin
    req_ready = '0;
    if (grant_any) req_ready[grant_id] = 1'b1;
  end

  // With no winner the address bus parks on the last issued address.
  assign mem_addr     = grant_any ? req_addr[grant_id*ADDR_W +: ADDR_W] : mem_addr_q;
  assign mem_data_in  = req_wdata[grant_id*DATA_W +: DATA_W];
  assign mem_write_en = grant_any & req_write[grant_id];

  always_comb begin
    rr_ptr_d   = rr_ptr_q;
    mem_addr_d = mem_addr;
    if (grant_any) begin
      rr_ptr_d = (grant_id == ID_W'(NUM_REQ-1)) ? '0 : grant_id + 1'b1;
    end
  end

  // Tag shift register: stage 0 records the accepted read, the last stage
  // lines up with mem_data_out. Shifting the whole packed array keeps this
  // valid for READ_LATENCY = 1 as well.
  always_comb begin
    tag_d        = tag_q << TAG_W;
    tag_d[0].vld = grant_any & ~req_write[grant_id];
    tag_d[0].id  = grant_id;
  end

  always_comb begin
    rsp_valid = '0;
    if (tag_q[READ_LATENCY-1].vld) rsp_valid[tag_q[READ_LATENCY-1].id] = 1'b1;
  end

  assign rsp_data = mem_data_out;

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q   <= '0;
      mem_addr_q <= '0;
      tag_q      <= '0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      mem_addr_q <= mem_addr_d;
      tag_q      <= tag_d;
    end
  end

endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
- Shares one single-port synchronous RAM (8-bit address, 8-bit data, registered address, registered read data) between NUM_REQ requesters.
- Round-robin arbitration: at most one access (read or write) is issued to the RAM per cycle.
- Read-tag pipeline matched to the RAM read latency routes each read result back to the requester that issued it.
- Sits between client blocks and the memory instance; the RAM is instantiated outside this block.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- ADDR_W, 8, address width.
- DATA_W, 8, data width.
- READ_LATENCY, 2, cycles from address issue to valid mem_data_out (the RAM registers the address, then registers the data).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous active-high reset.
- req_valid  input  NUM_REQ  per-requester request valid.
- req_ready  output  NUM_REQ  per-requester grant; the request is accepted when valid and ready are both high.
- req_write  input  NUM_REQ  1 = write, 0 = read.
- req_addr  input  NUM_REQ*ADDR_W  flattened addresses; requester i uses bits [i*ADDR_W +: ADDR_W].
- req_wdata  input  NUM_REQ*DATA_W  flattened write data.
- rsp_valid  output  NUM_REQ  one-cycle pulse; read data for requester i is valid.
- rsp_data  output  DATA_W  read data, shared by all requesters; qualify with rsp_valid.
- mem_addr  output  ADDR_W  to RAM addr.
- mem_write_en  output  1  to RAM write_en.
- mem_data_in  output  DATA_W  to RAM data_in.
- mem_data_out  input  DATA_W  from RAM data_out.

Behaviour:
- Reset values:
  - rr_ptr = 0 (requester 0 has highest priority).
  - Tag pipeline valid bits = 0.
  - rsp_valid = 0.
  - req_ready = 0 and mem_write_en = 0 while rst is high (both gated combinationally by rst).
- Arbitration (combinational):
  - Search for the first asserted req_valid, starting at index rr_ptr and wrapping modulo NUM_REQ.
  - The winner g gets req_ready[g] = 1; all other ready bits are 0.
  - If no request is valid, all ready bits are 0.
  - req_ready never depends on the winner's req_write (no read/write priority).
- Issue (combinational from the winner):
  - mem_addr = req_addr[g].
  - mem_data_in = req_wdata[g].
  - mem_write_en = req_write[g] & req_valid[g].
  - With no winner: mem_addr holds its last issued value (registered copy), and mem_write_en = 0.
- Pointer update: on an accepted request, rr_ptr <= (g+1) mod NUM_REQ. With no accept, rr_ptr holds.
- Fairness: with all requesters continuously valid, grants rotate 0,1,..,NUM_REQ-1. Each requester waits at most NUM_REQ-1 cycles.
- Read tags:
  - Shift register of READ_LATENCY stages, each holding {valid, id}.
  - Stage 0 loads {accepted & ~req_write[g], g}.
  - At the output stage: rsp_valid[id] = valid, and rsp_data = mem_data_out.
  - Result: read data appears exactly READ_LATENCY cycles after acceptance.
- Throughput: one access per cycle, and back-to-back reads are fully pipelined. Responses have no backpressure; clients must sink rsp_valid.
- Ordering: responses return in issue order.
- Write/read hazards:
  - A write at cycle k followed by a read of the same address at cycle k+1 returns the new data, since the RAM samples its array one cycle after address capture.
  - No forwarding logic is required in this block.
- Writes produce no response.
- Reset mid-operation: all in-flight tags are discarded, and no rsp_valid is asserted for reads issued before rst. The RAM contents are unaffected.
- Requests are not required to hold stable while not ready, but the bench holds them stable.

Test Plan:
- Single read: after rst, requester 0 writes 0x5A to 0x10; next cycle requester 0 reads 0x10 -> rsp_valid[0] pulses exactly 2 cycles after the read accept, rsp_data = 0x5A, rsp_valid[1] stays 0.
- Contention: both requesters valid for 6 cycles reading addresses 0x01 (req 0) and 0x02 (req 1), preloaded with 0xA1/0xB2 -> grants alternate 0,1,0,1,0,1; responses alternate id 0/1 with 0xA1/0xB2, each 2 cycles after its grant.
- Pointer hold: only req 1 is valid for 3 cycles, then both are valid -> req 1 granted 3 times, then req 0 granted first (rr_ptr = 0 after the last req 1 grant).
- Write/read collision: cycle k req 0 writes 0x33 to 0x40; cycle k+1 req 1 reads 0x40 -> rsp_valid[1] at k+3 with data 0x33; mem_write_en high only in cycle k.
- Reset mid-flight: issue a read at cycle k, assert rst at k+1 for one cycle -> no rsp_valid at k+2; req_ready = 0 during rst; rr_ptr = 0 afterwards.
- Idle: no req_valid for 10 cycles -> mem_write_en = 0, rsp_valid = 0, and mem_addr unchanged throughout.
